mmio_uart_tx: RTL and testbench
===============================

Name: mmio_uart_tx

Overview:
- Memory-mapped responder on the core's data bus (`address` / `data_out` / `data_in`), sitting beside the IO manager in the top level.
- The core writes bytes into a TX FIFO.
- An 8N1 UART transmitter drains the FIFO onto a serial pin.
- The core polls a status register for FIFO level, busy and overflow.
- Gives programs a character-output path independent of the seven-segment and LED debug views.

Parameters:
- BASE_ADDR, 32'hFFFF_0100, base of the 3-word register window; word-aligned.
- CLK_DIV, 868, clock cycles per serial bit (100 MHz / 115200); legal range 2..65535.
- FIFO_DEPTH, 8, TX FIFO entries; power of two, 2..64.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- address  input  32  byte address from core.
- data_out  input  32  write data from core.
- mem_write  input  1  write strobe; a write is accepted in any cycle it is high while `address` hits the window.
- data_in  output  32  read data to core; combinational from `address`.
- uart_tx  output  1  serial line, idle high.
- tx_busy  output  1  high while a frame is on the line (state != IDLE).

Behaviour:
- Reset values:
  - `uart_tx` = 1, `tx_busy` = 0.
  - FIFO empty, count 0, `overflow` = 0, `enable` = 1.
  - FSM in IDLE, baud counter 0.
  - `data_in` follows the read mux; with reset state and the STATUS address it reads 32'h0000_0002.
- Register map (offset from BASE_ADDR; address[1:0] ignored):
  - +0 TXDATA
    - Write: push data_out[7:0].
    - Read: returns 0.
  - +4 STATUS (read-only fields)
    - [0] full, [1] empty, [2] tx_busy, [3] overflow.
    - [15:8] FIFO count; other bits 0.
    - Write with data_out[3] = 1 clears `overflow`; other bits ignored.
  - +8 CTRL
    - [0] enable, read/write; other bits read 0.
  - Any other address: `data_in` = 0, writes ignored. Reads have no side effects.
- FIFO:
  - Circular buffer with log2(FIFO_DEPTH)-bit pointers that wrap naturally; count is a separate counter of width log2(FIFO_DEPTH)+1.
  - A push to TXDATA when count == FIFO_DEPTH and no pop that cycle: data dropped, `overflow` set (sticky).
  - Push and pop in the same cycle: both performed, count unchanged; legal even when full.
  - `overflow` clear and overflow set in the same cycle: set wins.
- Transmit FSM: IDLE, START, DATA, STOP.
  - IDLE: if enable = 1 and FIFO not empty:
    - pop the head into the shift register;
    - load baud counter with CLK_DIV-1;
    - go to START; `uart_tx` = 0 from the next cycle.
  - Each state holds the line for exactly CLK_DIV cycles. The counter decrements to 0, then reloads CLK_DIV-1 on transition.
  - START: line 0, then go to DATA with bit index 0.
  - DATA: line = shift[0]. At counter 0, shift right and increment the index; after bit 7, go to STOP.
  - STOP: line 1 for CLK_DIV cycles, then return to IDLE.
  - Frame length: 10*CLK_DIV cycles. Back-to-back frames have no idle gap beyond the single IDLE cycle.
  - Clearing enable mid-frame finishes the current frame; no new frame starts until enable = 1.
- Reset mid-frame: `uart_tx` returns to 1 on the cycle after `rst` is sampled high; FIFO contents are discarded.
- Latency: a push to an empty FIFO with enable = 1 and FSM in IDLE gives a start bit on the line 2 cycles after the write edge (1 cycle FIFO write, 1 cycle IDLE pop).

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP; it drives the even parity (XOR of the 8 data bits) for CLK_DIV cycles.
  - Frame length is 11*CLK_DIV cycles.
  - STATUS[4] reads 1.
- Undefined: 8N1 only, and STATUS[4] reads 0.

Test Plan:
- Basic frame: CLK_DIV=4. Reset, then write 8'hA5 to BASE+0. Required:
  - `uart_tx` goes low 2 cycles later;
  - line shows 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles;
  - `tx_busy` high for 40 cycles.
- Status read:
  - After reset, read BASE+4: data_in = 32'h0000_0002.
  - With enable=0 and 3 pushes: data_in = 32'h0000_0300.
- Overflow: FIFO_DEPTH=8, enable=0. Push 9 bytes 0x01..0x09. Required:
  - STATUS = 32'h0000_0809 (full, overflow, count 8);
  - after write BASE+4 with 32'h8, STATUS = 32'h0000_0801.
- Full push+pop: FIFO full and FSM in IDLE. Set enable=1 in the same cycle as a push. Required:
  - count stays 8, overflow stays 0;
  - all 9 bytes transmitted in order.
- Reset mid-frame: assert `rst` during DATA bit 3. Required:
  - `uart_tx` = 1 and `tx_busy` = 0 the next cycle;
  - STATUS = 32'h0000_0002.
- Parity (UART_TX_PARITY_EN): write 8'h07. Required: parity bit = 1, frame 44 cycles at CLK_DIV=4.

Source files
------------

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped TX FIFO drained by an 8N1 UART transmitter.
// Define UART_TX_PARITY_EN to insert an even parity bit between data and stop.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0100,
    parameter int          CLK_DIV    = 868,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic [31:0] data_out,
    input  logic        mem_write,
    output logic [31:0] data_in,
    output logic        uart_tx,
    output logic        tx_busy
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [15:0] DIV_M1 = 16'(CLK_DIV - 1);
`ifdef UART_TX_PARITY_EN
    localparam logic PAR_EN = 1'b1;
`else
    localparam logic PAR_EN = 1'b0;
`endif
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t state, state_n;
    logic [7:0] mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [PW:0] count;
    logic [7:0] shift, shift_n;
    logic [2:0] idx, idx_n;
    logic [15:0] cnt, cnt_n;
    logic [31:0] off;
    logic overflow, enable, parity;
    logic sel_tx, sel_st, sel_ct, full, empty, push, pop, do_push, tick, clr_ovf;
    logic unused;
    assign off = address - BASE_ADDR;
    assign sel_tx = off[31:2] == 30'd0;
    assign sel_st = off[31:2] == 30'd1;
    assign sel_ct = off[31:2] == 30'd2;
    assign unused = ^{data_out[31:8], off[1:0]};
    assign full = count == (PW+1)'(FIFO_DEPTH);
    assign empty = count == '0;
    assign pop = state == IDLE && enable && !empty;
    assign push = mem_write && sel_tx;
    // a simultaneous pop frees the slot, so a push into a full FIFO is still legal
    assign do_push = push && (!full || pop);
    assign clr_ovf = mem_write && sel_st && data_out[3];
    assign tick = cnt == '0;
    assign tx_busy = state != IDLE;
    always_comb begin
        data_in = '0;
        if (sel_st)
            data_in = {16'd0, 8'(count), 3'd0, PAR_EN, overflow, tx_busy, empty, full};
        else if (sel_ct)
            data_in = {31'd0, enable};
    end
    always_comb begin
        state_n = state;
        shift_n = shift;
        idx_n = idx;
        cnt_n = tick ? DIV_M1 : cnt - 16'd1;
        uart_tx = 1'b1;
        case (state)
            IDLE: begin
                cnt_n = pop ? DIV_M1 : '0;
                shift_n = pop ? mem[rd_ptr] : shift;
                state_n = pop ? START : IDLE;
            end
            START: begin
                uart_tx = 1'b0;
                state_n = tick ? DATA : START;
                idx_n = tick ? 3'd0 : idx;
            end
            DATA: begin
                uart_tx = shift[0];
                shift_n = tick ? shift >> 1 : shift;
                idx_n = tick ? idx + 3'd1 : idx;
                if (tick && idx == 3'd7)
                    state_n = PAR_EN ? PARITY : STOP;
            end
            PARITY: begin
                uart_tx = parity;
                state_n = tick ? STOP : PARITY;
            end
            STOP: state_n = tick ? IDLE : STOP;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= data_out[7:0];
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
            overflow <= 1'b0;
            enable <= 1'b1;
            shift <= '0;
            idx <= '0;
            cnt <= '0;
            parity <= 1'b0;
        end else begin
            state <= state_n;
            wr_ptr <= wr_ptr + PW'(do_push);
            rd_ptr <= rd_ptr + PW'(pop);
            count <= count + (PW+1)'(do_push) - (PW+1)'(pop);
            overflow <= (push && full && !pop) || (overflow && !clr_ovf);
            enable <= (mem_write && sel_ct) ? data_out[0] : enable;
            shift <= shift_n;
            idx <= idx_n;
            cnt <= cnt_n;
            parity <= pop ? ^mem[rd_ptr] : parity;
        end
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: randomized self-checking bench for mmio_uart_tx at CLK_DIV=4, FIFO_DEPTH=8.
module tb_mmio_uart_tx;
    localparam int DIV = 4;
    localparam logic [31:0] BASE = 32'hFFFF_0100;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
    localparam logic [31:0] PB = 32'h10;
`else
    localparam int NB = 10;
    localparam logic [31:0] PB = 32'h0;
`endif
    logic clk = 1'b0, rst = 1'b1, mem_write = 1'b0;
    logic [31:0] address = '0, data_out = '0;
    logic [31:0] data_in;
    logic uart_tx, tx_busy;
    int n_cmp = 0, n_bad = 0;
    mmio_uart_tx #(.BASE_ADDR(BASE), .CLK_DIV(DIV), .FIFO_DEPTH(8)) dut (
        .clk(clk), .rst(rst), .address(address), .data_out(data_out),
        .mem_write(mem_write), .data_in(data_in), .uart_tx(uart_tx), .tx_busy(tx_busy)
    );
    always #5 clk = ~clk;

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        address = a;
        data_out = d;
        mem_write = 1'b1;
        @(negedge clk);
        mem_write = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        address = a;
        #1 d = data_in;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [31:0] status_of(int cnt, bit ovf, bit busy);
        return PB | (32'(cnt) << 8) | {28'd0, ovf, busy, 1'(cnt == 0), 1'(cnt == 8)};
    endfunction

    function automatic logic frame_bit(logic [7:0] b, int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (k == 9 && NB == 11) return ^b;
        return 1'b1;
    endfunction

    task automatic check_status(input string nm, input logic [31:0] exp);
        logic [31:0] d;
        rd(BASE + 32'd4, d);
        n_cmp++;
        if (d !== exp) begin
            n_bad++;
            $display("FAIL %s: status got %08h expected %08h", nm, d, exp);
        end
    endtask

    task automatic check_frame(input string nm, input logic [7:0] b, input int gap);
        int w = 0, bad = -1;
        logic bt = 1'b0, bb = 1'b0;
        while (uart_tx !== 1'b0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        n_cmp++;
        if (w >= 200) begin
            n_bad++;
            $display("FAIL %s: no start bit within %0d cycles", nm, w);
            return;
        end
        for (int i = 0; i < NB * DIV; i++) begin
            if (bad < 0 && (uart_tx !== frame_bit(b, i / DIV) || tx_busy !== 1'b1)) begin
                bad = i;
                bt = uart_tx;
                bb = tx_busy;
            end
            @(negedge clk);
        end
        if (bad >= 0) begin
            n_bad++;
            $display("FAIL %s: byte %02h cycle %0d got tx=%b busy=%b expected tx=%b busy=1",
                     nm, b, bad, bt, bb, frame_bit(b, bad / DIV));
        end
        if (gap >= 0) begin
            n_cmp++;
            if (w !== gap) begin
                n_bad++;
                $display("FAIL %s_gap: start after %0d cycles expected %0d", nm, w, gap);
            end
        end
    endtask

    task automatic check_idle(input string nm, input int cycles);
        int bad = 0;
        for (int i = 0; i < cycles; i++) begin
            if (uart_tx !== 1'b1 || tx_busy !== 1'b0) bad++;
            @(negedge clk);
        end
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL %s: line not idle in %0d of %0d cycles (expected tx=1 busy=0)", nm, bad, cycles);
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        do_reset();
        n_cmp++;
        if (uart_tx !== 1'b1 || tx_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_line: tx=%b busy=%b expected tx=1 busy=0", uart_tx, tx_busy);
        end
        check_status("reset_status", status_of(0, 0, 0));
        rd(BASE + 32'd8, d);
        n_cmp++;
        if (d !== 32'h1) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %08h expected 00000001", d);
        end
        rd(BASE, d);
        n_cmp++;
        if (d !== 32'h0) begin
            n_bad++;
            $display("FAIL txdata_read: got %08h expected 00000000", d);
        end
        rd(BASE + 32'd12 + 32'(4 * $urandom_range(0, 1000)), d);
        n_cmp++;
        if (d !== 32'h0) begin
            n_bad++;
            $display("FAIL outside_above: got %08h expected 00000000", d);
        end
        rd(BASE - 32'd4, d);
        n_cmp++;
        if (d !== 32'h0) begin
            n_bad++;
            $display("FAIL outside_below: got %08h expected 00000000", d);
        end
        @(negedge clk);
    endtask

    task automatic test_basic_frame();
        logic [7:0] b;
        for (int k = 0; k < 4; k++) begin
            b = (k == 0) ? 8'hA5 : 8'($urandom);
            wr(BASE, {24'($urandom), b});
            check_frame("basic_frame", b, 1);
            n_cmp++;
            if (tx_busy !== 1'b0 || uart_tx !== 1'b1) begin
                n_bad++;
                $display("FAIL frame_end: tx=%b busy=%b expected tx=1 busy=0", uart_tx, tx_busy);
            end
        end
    endtask

    task automatic test_status_overflow();
        logic [31:0] d;
        do_reset();
        wr(BASE + 32'd8, 32'h0);
        for (int i = 1; i <= 3; i++) wr(BASE, 32'(i));
        check_status("status_3", status_of(3, 0, 0));
        for (int i = 4; i <= 9; i++) wr(BASE, 32'(i));
        check_status("overflow_set", status_of(8, 1, 0));
        wr(BASE + 32'd4, $urandom & ~32'h8);
        check_status("overflow_kept", status_of(8, 1, 0));
        wr(BASE + 32'd4, $urandom | 32'h8);
        check_status("overflow_clr", status_of(8, 0, 0));
        rd(BASE + 32'd8, d);
        n_cmp++;
        if (d !== 32'h0) begin
            n_bad++;
            $display("FAIL ctrl_read: got %08h expected 00000000", d);
        end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] x = 8'($urandom);
        logic [7:0] q[$];
        for (int i = 1; i <= 8; i++) q.push_back(8'(i));
        q.push_back(x);
        wr(BASE + 32'd8, 32'h1);
        wr(BASE, {24'd0, x});
        check_status("full_push_pop", status_of(8, 0, 1));
        for (int i = 0; i < 9; i++) check_frame("full_order", q[i], i == 0 ? -1 : 1);
        check_idle("full_drained", 20);
        check_status("full_empty", status_of(0, 0, 0));
    endtask

    task automatic test_enable_gate();
        logic [7:0] b1 = 8'($urandom), b2 = 8'($urandom);
        do_reset();
        wr(BASE + 32'd8, 32'h0);
        wr(BASE, {24'd0, b1});
        wr(BASE, {24'd0, b2});
        check_idle("disabled_idle", 30);
        wr(BASE + 32'd8, 32'h1);
        fork
            check_frame("enable_midframe", b1, 1);
            begin
                repeat (12) @(negedge clk);
                wr(BASE + 32'd8, 32'h0);
            end
        join
        check_idle("held_after_clear", 50);
        check_status("held_status", status_of(1, 0, 0));
        wr(BASE + 32'd8, 32'h1);
        check_frame("enable_resume", b2, 1);
    endtask

    task automatic test_back_to_back();
        logic [7:0] q[$];
        int n = $urandom_range(3, 6);
        do_reset();
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
        wr(BASE, {24'd0, q[0]});
        fork
            check_frame("b2b", q[0], 1);
            for (int i = 1; i < n; i++) wr(BASE, {24'($urandom), q[i]});
        join
        for (int i = 1; i < n; i++) check_frame("b2b", q[i], 1);
        check_idle("b2b_end", 10);
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b = 8'($urandom);
        do_reset();
        wr(BASE, {24'd0, b});
        @(negedge clk);
        wr(BASE, 32'($urandom));
        wr(BASE, 32'($urandom));
        repeat (15) @(negedge clk);
        n_cmp++;
        if (uart_tx !== b[3] || tx_busy !== 1'b1) begin
            n_bad++;
            $display("FAIL bit3_before_reset: tx=%b busy=%b expected tx=%b busy=1", uart_tx, tx_busy, b[3]);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if (uart_tx !== 1'b1 || tx_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid_frame: tx=%b busy=%b expected tx=1 busy=0", uart_tx, tx_busy);
        end
        check_status("reset_mid_status", status_of(0, 0, 0));
        check_idle("reset_discard", 60);
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        do_reset();
        wr(BASE, 32'h07);
        check_frame("parity_07", 8'h07, 1);
        n_cmp++;
        if (tx_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL parity_len: busy=%b after 44 cycles expected 0", tx_busy);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_frame();
        test_status_overflow();
        test_full_push_pop();
        test_enable_gate();
        test_back_to_back();
        test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
